// File: rtl/printer_job_scheduler_pkg.sv
// printer_job_scheduler_pkg: shared FSM state type and constants for the printer job scheduler (package printer_pkg).
package printer_pkg;
  typedef enum logic [1:0] {P_IDLE, P_WARM, P_PRINT, P_REL} prn_state_t;
  localparam int USING_FREE = 0;
endpackage

// File: rtl/printer_job_scheduler_if.sv
// printer_job_scheduler_if: requester/printer-engine signals of the scheduler; master = requesters + engine, slave = scheduler.
interface printer_job_scheduler_if #(
  parameter int NREQ = 3,
  parameter int PG_W = 8
);
  localparam int UW = $clog2(NREQ + 1);
  logic [NREQ-1:0] req;
  logic [NREQ*PG_W-1:0] pages;
  logic page_done;
  logic [NREQ-1:0] grant_onehot;
  logic [UW-1:0] usingby;
  logic print_en;
  logic [PG_W-1:0] pages_left;
  logic job_done;
  logic job_abort;
  modport master (
    output req, pages, page_done,
    input grant_onehot, usingby, print_en, pages_left, job_done, job_abort
  );
  modport slave (
    input req, pages, page_done,
    output grant_onehot, usingby, print_en, pages_left, job_done, job_abort
  );
endinterface

// File: rtl/printer_job_scheduler_rr_pick.sv
// rr_pick: combinational round-robin picker; searches elig from ptr+1 modulo NREQ, returns one-hot winner, its index and any.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         onehot,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk the search order backwards so the last hit is the first in round-robin order.
    for (int k = NREQ; k >= 1; k--)
      if (elig[IW'((int'(ptr) + k) % NREQ)]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + k) % NREQ);
      end
    onehot = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/printer_job_scheduler.sv
// printer_job_scheduler: shares one printer among NREQ requesters with round-robin grant, warm-up and page counting.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : req/pages/page_done in; grant_onehot/usingby/print_en/pages_left/job_done/job_abort out (all registered)
//   PRINTER_TIMEOUT_EN: when defined, aborts a job after MAX_STALL PRINT cycles without page_done.
module printer_job_scheduler
  import printer_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int PG_W      = 8,
  parameter int WARMUP    = 4,
  parameter int MAX_STALL = 64
) (
  input logic clk,
  input logic rst,
  printer_job_scheduler_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int UW = $clog2(NREQ + 1);
  localparam int WW = $clog2(WARMUP + 1);
  prn_state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, widx;
  logic [NREQ-1:0] elig, wone, grant, grant_n;
  logic [UW-1:0] usingby, usingby_n;
  logic [PG_W-1:0] pl, pl_n, wpages;
  logic [WW-1:0] wcnt, wcnt_n;
  logic any, owner_on, stall_hit, done_n, abort_n, job_done, job_abort, print_en;
  always_comb
    for (int i = 0; i < NREQ; i++)
      elig[i] = bus.req[i] && bus.pages[i*PG_W +: PG_W] != '0;
  rr_pick #(.NREQ(NREQ)) u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .onehot (wone),
    .idx    (widx),
    .any    (any)
  );
  assign wpages = bus.pages[widx*PG_W +: PG_W];
  assign owner_on = |(bus.req & grant);
`ifdef PRINTER_TIMEOUT_EN
  localparam int SW = $clog2(MAX_STALL + 1);
  logic [SW-1:0] stall;
  always_ff @(posedge clk)
    stall <= (rst || state != P_PRINT || bus.page_done) ? '0 : stall + 1'b1;
  assign stall_hit = state == P_PRINT && !bus.page_done && stall == SW'(MAX_STALL - 1);
`else
  assign stall_hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    grant_n = grant;
    usingby_n = usingby;
    pl_n = pl;
    wcnt_n = wcnt;
    done_n = 1'b0;
    abort_n = 1'b0;
    case (state)
      P_IDLE, P_REL: begin
        // Coming from REL the printer is still warm, so a new owner starts printing at once.
        state_n = !any ? P_IDLE : state == P_IDLE ? P_WARM : P_PRINT;
        ptr_n = any ? widx : ptr;
        grant_n = wone;
        usingby_n = any ? UW'(widx) + UW'(1) : UW'(USING_FREE);
        pl_n = any ? wpages : '0;
        wcnt_n = '0;
      end
      P_WARM: begin
        abort_n = !owner_on;
        state_n = !owner_on ? P_REL : wcnt == WW'(WARMUP - 1) ? P_PRINT : P_WARM;
        wcnt_n = wcnt + 1'b1;
      end
      default: begin
        // An abort outranks a page_done arriving in the same cycle.
        abort_n = !owner_on || stall_hit;
        done_n = !abort_n && bus.page_done && pl == PG_W'(1);
        pl_n = !abort_n && bus.page_done ? pl - 1'b1 : pl;
        state_n = abort_n || done_n ? P_REL : P_PRINT;
      end
    endcase
    if (state_n == P_REL) begin
      grant_n = '0;
      usingby_n = UW'(USING_FREE);
      pl_n = '0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= P_IDLE;
      ptr <= IW'(NREQ - 1);
      grant <= '0;
      usingby <= UW'(USING_FREE);
      pl <= '0;
      wcnt <= '0;
      print_en <= 1'b0;
      job_done <= 1'b0;
      job_abort <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant <= grant_n;
      usingby <= usingby_n;
      pl <= pl_n;
      wcnt <= wcnt_n;
      print_en <= state_n == P_PRINT;
      job_done <= done_n;
      job_abort <= abort_n;
    end
  assign bus.grant_onehot = grant;
  assign bus.usingby = usingby;
  assign bus.print_en = print_en;
  assign bus.pages_left = pl;
  assign bus.job_done = job_done;
  assign bus.job_abort = job_abort;
endmodule

// File: tb/tb_printer_job_scheduler.sv
// tb_printer_job_scheduler: table-driven cycle vectors plus stall-timeout sequence for printer_job_scheduler.
module tb_printer_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  printer_job_scheduler_if #(.NREQ(3), .PG_W(8)) bus ();
  printer_job_scheduler #(.NREQ(3), .PG_W(8), .WARMUP(4), .MAX_STALL(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  typedef struct {
    logic r;
    logic [2:0] req;
    logic [23:0] pg;
    logic pd;
    logic [15:0] exp;
  } vec_t;
  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  task automatic v(input logic r, input logic [2:0] req, input logic [23:0] pg, input logic pd,
                   input logic [2:0] g, input logic [1:0] u, input logic pe, input logic [7:0] pl,
                   input logic d, input logic a);
    vec_t t;
    t.r = r;
    t.req = req;
    t.pg = pg;
    t.pd = pd;
    t.exp = {g, u, pe, pl, d, a};
    vq.push_back(t);
  endtask
  function automatic logic [15:0] act();
    return {bus.grant_onehot, bus.usingby, bus.print_en, bus.pages_left, bus.job_done, bus.job_abort};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got g/u/pe/pl/d/a=%h required %h", nm, got, want);
    end
  endtask
  initial begin
    bus.req = '0;
    bus.pages = '0;
    bus.page_done = 1'b0;
    // Single job: 4 WARM cycles, page_done in WARM ignored, 2 pages, REL then IDLE.
    v(1, 3'b000, 24'h000000, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b001, 24'h000002, 0, 3'b001, 1, 0, 2, 0, 0);
    v(0, 3'b001, 24'h000002, 0, 3'b001, 1, 0, 2, 0, 0);
    v(0, 3'b001, 24'h000002, 1, 3'b001, 1, 0, 2, 0, 0);
    v(0, 3'b001, 24'h000002, 0, 3'b001, 1, 0, 2, 0, 0);
    v(0, 3'b001, 24'h000002, 0, 3'b001, 1, 1, 2, 0, 0);
    v(0, 3'b001, 24'h000002, 1, 3'b001, 1, 1, 1, 0, 0);
    v(0, 3'b001, 24'h000002, 0, 3'b001, 1, 1, 1, 0, 0);
    v(0, 3'b001, 24'h000002, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b000, 24'h000002, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b000, 24'h000002, 1, 3'b000, 0, 0, 0, 0, 0);
    // All three requesting one page each: owners 0,1,2,0, only the first warms up.
    v(1, 3'b000, 24'h000000, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 0, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 0, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 0, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 0, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 1, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b010, 2, 1, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b100, 3, 1, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b111, 24'h010101, 0, 3'b001, 1, 1, 1, 0, 0);
    v(0, 3'b111, 24'h010101, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b000, 24'h010101, 0, 3'b000, 0, 0, 0, 0, 0);
    // Owner 1 drops req at pages_left=3 with a coincident page_done: abort wins, owner 2 follows without WARM.
    v(1, 3'b000, 24'h000000, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b110, 24'h020500, 0, 3'b010, 2, 0, 5, 0, 0);
    v(0, 3'b110, 24'h020500, 0, 3'b010, 2, 0, 5, 0, 0);
    v(0, 3'b110, 24'h020500, 0, 3'b010, 2, 0, 5, 0, 0);
    v(0, 3'b110, 24'h020500, 0, 3'b010, 2, 0, 5, 0, 0);
    v(0, 3'b110, 24'h020500, 0, 3'b010, 2, 1, 5, 0, 0);
    v(0, 3'b110, 24'h020500, 1, 3'b010, 2, 1, 4, 0, 0);
    v(0, 3'b110, 24'h020500, 1, 3'b010, 2, 1, 3, 0, 0);
    v(0, 3'b100, 24'h020500, 1, 3'b000, 0, 0, 0, 0, 1);
    v(0, 3'b100, 24'h020500, 0, 3'b100, 3, 1, 2, 0, 0);
    v(0, 3'b100, 24'h020500, 1, 3'b100, 3, 1, 1, 0, 0);
    v(0, 3'b100, 24'h020500, 1, 3'b000, 0, 0, 0, 1, 0);
    v(0, 3'b000, 24'h020500, 0, 3'b000, 0, 0, 0, 0, 0);
    // Owner drops req during WARM.
    v(0, 3'b001, 24'h000001, 0, 3'b001, 1, 0, 1, 0, 0);
    v(0, 3'b000, 24'h000001, 0, 3'b000, 0, 0, 0, 0, 1);
    v(0, 3'b000, 24'h000001, 0, 3'b000, 0, 0, 0, 0, 0);
    // Zero-page request is never granted; page_done in IDLE has no effect.
    v(1, 3'b000, 24'h000000, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b010, 24'h070007, 1, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b010, 24'h070007, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b010, 24'h070007, 1, 3'b000, 0, 0, 0, 0, 0);
    // Reset mid-PRINT clears everything and restarts the search at requester 0.
    v(1, 3'b000, 24'h000000, 0, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b001, 24'h030205, 0, 3'b001, 1, 0, 5, 0, 0);
    v(0, 3'b001, 24'h030205, 0, 3'b001, 1, 0, 5, 0, 0);
    v(0, 3'b001, 24'h030205, 0, 3'b001, 1, 0, 5, 0, 0);
    v(0, 3'b001, 24'h030205, 0, 3'b001, 1, 0, 5, 0, 0);
    v(0, 3'b001, 24'h030205, 0, 3'b001, 1, 1, 5, 0, 0);
    v(1, 3'b111, 24'h030205, 1, 3'b000, 0, 0, 0, 0, 0);
    v(0, 3'b011, 24'h030205, 0, 3'b001, 1, 0, 5, 0, 0);
    v(0, 3'b000, 24'h030205, 0, 3'b000, 0, 0, 0, 0, 1);
    foreach (vq[i]) begin
      rst = vq[i].r;
      bus.req = vq[i].req;
      bus.pages = vq[i].pg;
      bus.page_done = vq[i].pd;
      step();
      chk($sformatf("vec%0d", i), act(), vq[i].exp);
    end
    // Stalled PRINT with no page_done.
    rst = 1'b1;
    bus.req = 3'b000;
    bus.page_done = 1'b0;
    step();
    rst = 1'b0;
    bus.req = 3'b001;
    bus.pages = 24'h000003;
    repeat (5) step();
    chk("stall_start", act(), {3'b001, 2'd1, 1'b1, 8'd3, 1'b0, 1'b0});
`ifdef PRINTER_TIMEOUT_EN
    repeat (63) step();
    chk("stall_63", act(), {3'b001, 2'd1, 1'b1, 8'd3, 1'b0, 1'b0});
    step();
    chk("stall_timeout", act(), {3'b000, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1});
`else
    repeat (1000) step();
    chk("stall_wait", act(), {3'b001, 2'd1, 1'b1, 8'd3, 1'b0, 1'b0});
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
